// File: rtl/sram_responder.sv
// On-chip synchronous SRAM that responds to the LC-3 datapath's active-low
// CE/OE/WE/UB/LB strobe protocol. It also provides a host preload port, a sticky
// protocol-error flag and a wrapping access counter.
module sram_responder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic [15:0] Addr,
    input  logic [15:0] Data_to_mem,
    output logic [15:0] Data_from_mem,
    output logic        Data_valid,
    input  logic        Init_we,
    input  logic [15:0] Init_addr,
    input  logic [15:0] Init_data,
    output logic        Init_ack,
    output logic        Err,
    output logic [15:0] Access_count
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [2:0] {StIdle, StRd1, StRdHold, StWr1, StWrHold} state_e;

    logic [15:0]       mem [Depth];

    state_e            state_q, state_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              wr_ub_q, wr_ub_d;   // active-high byte enables
    logic              wr_lb_q, wr_lb_d;
    logic              commit;
    logic              rd_req, wr_req;

    // Upper address bits alias onto the array; they are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{Addr, Init_addr};

    assign rd_req = ~Mem_CE & ~Mem_OE;
    assign wr_req = ~Mem_CE & ~Mem_WE;

    // Next-state, counter, error and preload-acknowledge logic.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        count_d   = count_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ub_d   = wr_ub_q;
        wr_lb_d   = wr_lb_q;
        commit    = 1'b0;
        Init_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_req && wr_req) begin
                    err_d = 1'b1;
                end else if (rd_req) begin
                    rdata_d = mem[Addr[ADDR_W-1:0]];
                    count_d = count_q + 16'd1;
                    state_d = StRd1;
                end else if (wr_req) begin
                    wr_addr_d = Addr[ADDR_W-1:0];
                    wr_data_d = Data_to_mem;
                    wr_ub_d   = ~Mem_UB;
                    wr_lb_d   = ~Mem_LB;
                    state_d   = StWr1;
                end else if (Init_we && !Reset) begin
                    Init_ack = 1'b1;
                end
            end
            StRd1, StRdHold: begin
                state_d = rd_req ? StRdHold : StIdle;
            end
            StWr1: begin
                if (wr_req) begin
                    commit  = 1'b1;
                    count_d = count_q + 16'd1;
                    state_d = StWrHold;
                end else begin
                    // WE pulse too short to be a legal write.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrHold: begin
                state_d = wr_req ? StWrHold : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            rdata_q   <= 16'h0000;
            err_q     <= 1'b0;
            count_q   <= 16'h0000;
            wr_addr_q <= '0;
            wr_data_q <= 16'h0000;
            wr_ub_q   <= 1'b0;
            wr_lb_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            count_q   <= count_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_ub_q   <= wr_ub_d;
            wr_lb_q   <= wr_lb_d;
        end
    end

    // Array writes; contents survive reset but no write happens while it is held.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (Init_ack) begin
                mem[Init_addr[ADDR_W-1:0]] <= Init_data;
            end
            if (commit) begin
                if (wr_ub_q) mem[wr_addr_q][15:8] <= wr_data_q[15:8];
                if (wr_lb_q) mem[wr_addr_q][7:0]  <= wr_data_q[7:0];
            end
        end
    end

    assign Data_valid    = (state_q == StRd1) || (state_q == StRdHold);
    assign Data_from_mem = Data_valid ? rdata_q : 16'h0000;
    assign Err           = err_q;
    assign Access_count  = count_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: preload, reads, full/byte writes, protocol
// errors, address aliasing, read interlock, fetch replay and counter wrap.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_CE = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1, Mem_UB = 1'b1, Mem_LB = 1'b1;
    logic [15:0] Addr = 16'h0000, Data_to_mem = 16'h0000;
    logic [15:0] Data_from_mem;
    logic        Data_valid;
    logic        Init_we = 1'b0;
    logic [15:0] Init_addr = 16'h0000, Init_data = 16'h0000;
    logic        Init_ack, Err;
    logic [15:0] Access_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_count = 16'h0000;

    sram_responder #(.ADDR_W(10)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Mem_CE       (Mem_CE),
        .Mem_OE       (Mem_OE),
        .Mem_WE       (Mem_WE),
        .Mem_UB       (Mem_UB),
        .Mem_LB       (Mem_LB),
        .Addr         (Addr),
        .Data_to_mem  (Data_to_mem),
        .Data_from_mem(Data_from_mem),
        .Data_valid   (Data_valid),
        .Init_we      (Init_we),
        .Init_addr    (Init_addr),
        .Init_data    (Init_data),
        .Init_ack     (Init_ack),
        .Err          (Err),
        .Access_count (Access_count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic strobes_off();
        Mem_CE = 1'b1;
        Mem_OE = 1'b1;
        Mem_WE = 1'b1;
        Mem_UB = 1'b1;
        Mem_LB = 1'b1;
    endtask

    task automatic do_reset();
        strobes_off();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        exp_count = 16'h0000;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        Init_we   = 1'b1;
        Init_addr = a;
        Init_data = d;
        #1;
        check("init_ack", {15'b0, Init_ack}, 16'd1);
        step();
        Init_we = 1'b0;
    endtask

    // OE low for two cycles, then one recovery cycle with strobes high.
    task automatic read_word(input string tag, input logic [15:0] a, input logic [15:0] exp);
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        Addr   = a;
        step();
        exp_count = exp_count + 16'd1;
        check({tag, "_valid1"}, {15'b0, Data_valid}, 16'd1);
        check({tag, "_data1"}, Data_from_mem, exp);
        check({tag, "_count"}, Access_count, exp_count);
        step();
        check({tag, "_data2"}, Data_from_mem, exp);
        strobes_off();
        step();
        check({tag, "_idle"}, Data_from_mem, 16'h0000);
    endtask

    // WE low for exactly two cycles, then one recovery cycle.
    task automatic write_word(input string tag, input logic [15:0] a, input logic [15:0] d,
                              input logic ub, input logic lb);
        Mem_CE      = 1'b0;
        Mem_WE      = 1'b0;
        Mem_UB      = ub;
        Mem_LB      = lb;
        Addr        = a;
        Data_to_mem = d;
        step();
        step();
        exp_count = exp_count + 16'd1;
        check({tag, "_count"}, Access_count, exp_count);
        strobes_off();
        step();
    endtask

    initial begin
        // Reset with a preload request pending: no ack, all outputs cleared.
        Init_we   = 1'b1;
        Init_addr = 16'h0030;
        step();
        step();
        #1;
        check("rst_ack", {15'b0, Init_ack}, 16'd0);
        check("rst_err", {15'b0, Err}, 16'd0);
        check("rst_valid", {15'b0, Data_valid}, 16'd0);
        check("rst_data", Data_from_mem, 16'h0000);
        check("rst_count", Access_count, 16'h0000);
        Init_we = 1'b0;
        Reset   = 1'b0;
        step();

        preload(16'h0005, 16'h1234);
        preload(16'h0011, 16'h5566);
        preload(16'h0020, 16'hA001);
        preload(16'h0021, 16'hB002);
        preload(16'h0022, 16'hC003);
        check("preload_count", Access_count, 16'h0000);

        read_word("rd5", 16'h0005, 16'h1234);

        write_word("wr_full", 16'h0010, 16'hBEEF, 1'b0, 1'b0);
        read_word("rd_full", 16'h0010, 16'hBEEF);

        write_word("wr_ub", 16'h0010, 16'h1200, 1'b0, 1'b1);
        read_word("rd_ub", 16'h0010, 16'h12EF);

        write_word("wr_none", 16'h0010, 16'hFFFF, 1'b1, 1'b1);
        read_word("rd_none", 16'h0010, 16'h12EF);

        write_word("wr_lb", 16'h0011, 16'h00AB, 1'b1, 1'b0);
        read_word("rd_lb", 16'h0011, 16'h55AB);

        // Single-cycle WE pulse: error, no write, no count.
        Mem_CE      = 1'b0;
        Mem_WE      = 1'b0;
        Mem_UB      = 1'b0;
        Mem_LB      = 1'b0;
        Addr        = 16'h0010;
        Data_to_mem = 16'h0000;
        step();
        strobes_off();
        step();
        check("short_err", {15'b0, Err}, 16'd1);
        check("short_count", Access_count, exp_count);
        read_word("rd_short", 16'h0010, 16'h12EF);
        check("err_sticky", {15'b0, Err}, 16'd1);

        do_reset();
        check("clr_err", {15'b0, Err}, 16'd0);
        check("clr_count", Access_count, 16'h0000);

        // OE and WE together: error, no access.
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        step();
        check("both_err", {15'b0, Err}, 16'd1);
        check("both_valid", {15'b0, Data_valid}, 16'd0);
        check("both_count", Access_count, 16'h0000);
        strobes_off();
        step();

        do_reset();
        check("rst2_err", {15'b0, Err}, 16'd0);
        read_word("rd_keep", 16'h0010, 16'h12EF);

        read_word("alias", 16'h0405, 16'h1234);

        // Preload and address changes during a read are ignored.
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        Addr   = 16'h0005;
        step();
        exp_count = exp_count + 16'd1;
        Init_we   = 1'b1;
        Init_addr = 16'h0005;
        Init_data = 16'hDEAD;
        Addr      = 16'h0006;
        #1;
        check("lock_ack1", {15'b0, Init_ack}, 16'd0);
        step();
        check("lock_ack2", {15'b0, Init_ack}, 16'd0);
        check("lock_data", Data_from_mem, 16'h1234);
        strobes_off();
        #1;
        check("lock_ack3", {15'b0, Init_ack}, 16'd0);
        step();
        Init_we = 1'b0;
        read_word("lock_rd", 16'h0005, 16'h1234);

        // Fetch replay: S_18 gap, S_33_1, S_33_2, S_35, three times.
        do_reset();
        step();
        read_word("fetch0", 16'h0020, 16'hA001);
        step();
        read_word("fetch1", 16'h0021, 16'hB002);
        step();
        read_word("fetch2", 16'h0022, 16'hC003);
        check("fetch_count", Access_count, 16'd3);

        // Counter wrap from 16'hFFFF.
        force dut.count_q = 16'hFFFF;
        step();
        release dut.count_q;
        check("wrap_pre", Access_count, 16'hFFFF);
        exp_count = 16'hFFFF;
        read_word("wrap", 16'h0020, 16'hA001);
        check("wrap_zero", Access_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
